// File: rtl/datapath_pkg.sv
// Shared types for the single-bus datapath: ALU op codes, bus source indices
// and the multiple-driver detector used by the optional bus checker.
package datapath_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOT = 4'd4,
        ALU_NEG = 4'd5,
        ALU_SHL = 4'd6,
        ALU_SHR = 4'd7,
        ALU_ROL = 4'd8,
        ALU_ROR = 4'd9,
        ALU_MUL = 4'd10,
        ALU_DIV = 4'd11
    } alu_op_e;

    // Bit positions of the non-GPR drive requests, lowest index = highest priority.
    localparam int SRC_HI        = 0;
    localparam int SRC_LO        = 1;
    localparam int SRC_ZHI       = 2;
    localparam int SRC_ZLO       = 3;
    localparam int SRC_PC        = 4;
    localparam int SRC_MDR       = 5;
    localparam int N_SPECIAL_SRC = 6;

    function automatic logic multi_request(input logic [63:0] req);
        return (req & (req - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/mul_div_seq.sv
// Iterative signed MUL/DIV: radix-2 shift/add multiply and restoring divide
// on operand magnitudes in one 2*DATA_W accumulator, sign fixed in the last cycle.
module mul_div_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic              res_we,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_e;

    md_state_e           state_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [DATA_W-1:0]   a_r, bmag_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                div_r, neg_r, sa_r, busy_r, done_r, dz_r;

    logic                accept_s;
    logic [DATA_W-1:0]   amag_s, bmag_s, quo_s, rem_s, fix_hi_s, fix_lo_s;
    logic [DATA_W:0]     sum_s, rem_sh_s, trial_s;
    logic [2*DATA_W-1:0] step_s, prod_s;

    // Operand magnitudes and one shift/add or shift/subtract iteration
    always_comb begin
        accept_s = start && (state_r == ST_IDLE) && ((op == ALU_MUL) || (op == ALU_DIV));
        amag_s   = a[DATA_W-1] ? (~a + {{(DATA_W-1){1'b0}}, 1'b1}) : a;
        bmag_s   = b[DATA_W-1] ? (~b + {{(DATA_W-1){1'b0}}, 1'b1}) : b;
        sum_s    = {1'b0, acc_r[2*DATA_W-1:DATA_W]}
                 + (acc_r[0] ? {1'b0, bmag_r} : {(DATA_W+1){1'b0}});
        rem_sh_s = acc_r[2*DATA_W-1:DATA_W-1];
        trial_s  = rem_sh_s - {1'b0, bmag_r};
        if (!div_r) begin
            step_s = {sum_s, acc_r[DATA_W-1:1]};
        end else if (!trial_s[DATA_W]) begin
            step_s = {trial_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
        end else begin
            step_s = {rem_sh_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
        end
    end

    // Sign correction of the unsigned magnitude result
    always_comb begin
        prod_s = neg_r ? (~acc_r + {{(2*DATA_W-1){1'b0}}, 1'b1}) : acc_r;
        quo_s  = neg_r ? (~acc_r[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_r[DATA_W-1:0];
        rem_s  = sa_r ? (~acc_r[2*DATA_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, 1'b1})
                      : acc_r[2*DATA_W-1:DATA_W];
        if (!div_r) begin
            fix_hi_s = prod_s[2*DATA_W-1:DATA_W];
            fix_lo_s = prod_s[DATA_W-1:0];
        end else if (dz_r) begin
            fix_hi_s = a_r;
            fix_lo_s = {DATA_W{1'b1}};
        end else begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end
    end

    // Control FSM: IDLE -> RUN (DATA_W iterations) -> FIX (result write) -> IDLE
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            acc_r   <= {(2*DATA_W){1'b0}};
            a_r     <= {DATA_W{1'b0}};
            bmag_r  <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            div_r   <= 1'b0;
            neg_r   <= 1'b0;
            sa_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        acc_r   <= {{DATA_W{1'b0}}, amag_s};
                        a_r     <= a;
                        bmag_r  <= bmag_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        div_r   <= (op == ALU_DIV);
                        neg_r   <= a[DATA_W-1] ^ b[DATA_W-1];
                        sa_r    <= a[DATA_W-1];
                        dz_r    <= (op == ALU_DIV) && (b == {DATA_W{1'b0}});
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = dz_r;
    assign res_we   = (state_r == ST_FIX);
    assign res_hi   = fix_hi_s;
    assign res_lo   = fix_lo_s;

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath: GPRs, PC, IR, Y, HI, LO, MDR and Z on one priority bus.
// Define DATAPATH_BUS_CHECK_EN to build the sticky multiple-driver detector.
module bus_datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NREGS-1:0]  r_in,
    input  logic [NREGS-1:0]  r_out,
    input  logic              pc_in,
    input  logic              pc_out,
    input  logic              ir_in,
    input  logic              y_in,
    input  logic              hi_in,
    input  logic              hi_out,
    input  logic              lo_in,
    input  logic              lo_out,
    input  logic              mdr_in,
    input  logic              mdr_out,
    input  logic              read,
    input  logic [DATA_W-1:0] mdatain,
    input  logic              z_in,
    input  logic              zhi_out,
    input  logic              zlo_out,
    input  logic [3:0]        alu_op,
    input  logic              alu_start,
    output logic              alu_busy,
    output logic              alu_done,
    output logic              div_zero,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] ir,
    output logic              bus_conflict
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   regs_r [NREGS];
    logic [DATA_W-1:0]   pc_r, ir_r, y_r, hi_r, lo_r, mdr_r, zhi_r, zlo_r;
    logic [DATA_W-1:0]   bus_s, alu_res_s, md_hi_s, md_lo_s;
    logic [2*DATA_W-1:0] rotl_s, rotr_s;
    logic [SH_W-1:0]     sh_s;
    logic                md_we_s;
    alu_op_e             op_s;

    assign op_s = alu_op_e'(alu_op);

    // Bus mux: lower-indexed GPRs beat higher ones, GPRs beat the special registers
    always_comb begin
        if (hi_out)        bus_s = hi_r;
        else if (lo_out)   bus_s = lo_r;
        else if (zhi_out)  bus_s = zhi_r;
        else if (zlo_out)  bus_s = zlo_r;
        else if (pc_out)   bus_s = pc_r;
        else if (mdr_out)  bus_s = mdr_r;
        else               bus_s = {DATA_W{1'b0}};
        for (int i = NREGS - 1; i >= 0; i--) begin
            bus_s = r_out[i] ? regs_r[i] : bus_s;
        end
    end

    // Single-cycle ALU, A = Y and B = bus; unary NOT/NEG act on the bus operand
    always_comb begin
        sh_s   = bus_s[SH_W-1:0];
        rotl_s = {y_r, y_r} << sh_s;
        rotr_s = {y_r, y_r} >> sh_s;
        case (op_s)
            ALU_ADD: alu_res_s = y_r + bus_s;
            ALU_SUB: alu_res_s = y_r - bus_s;
            ALU_AND: alu_res_s = y_r & bus_s;
            ALU_OR:  alu_res_s = y_r | bus_s;
            ALU_NOT: alu_res_s = ~bus_s;
            ALU_NEG: alu_res_s = ~bus_s + {{(DATA_W-1){1'b0}}, 1'b1};
            ALU_SHL: alu_res_s = y_r << sh_s;
            ALU_SHR: alu_res_s = y_r >> sh_s;
            ALU_ROL: alu_res_s = rotl_s[2*DATA_W-1:DATA_W];
            ALU_ROR: alu_res_s = rotr_s[DATA_W-1:0];
            default: alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    mul_div_seq #(.DATA_W(DATA_W)) u_mul_div (
        .clk      (clk),
        .clr      (clr),
        .start    (alu_start),
        .op       (op_s),
        .a        (y_r),
        .b        (bus_s),
        .busy     (alu_busy),
        .done     (alu_done),
        .div_zero (div_zero),
        .res_we   (md_we_s),
        .res_hi   (md_hi_s),
        .res_lo   (md_lo_s)
    );

    // Register file and special registers load from the bus
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
            pc_r  <= {DATA_W{1'b0}};
            ir_r  <= {DATA_W{1'b0}};
            y_r   <= {DATA_W{1'b0}};
            hi_r  <= {DATA_W{1'b0}};
            lo_r  <= {DATA_W{1'b0}};
            mdr_r <= {DATA_W{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_in[i]) regs_r[i] <= bus_s;
            end
            if (pc_in)  pc_r  <= bus_s;
            if (ir_in)  ir_r  <= bus_s;
            if (y_in)   y_r   <= bus_s;
            if (hi_in)  hi_r  <= bus_s;
            if (lo_in)  lo_r  <= bus_s;
            if (mdr_in) mdr_r <= read ? mdatain : bus_s;
        end
    end

    // Z capture: iterative result wins; single-cycle capture only while idle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_r <= {DATA_W{1'b0}};
            zlo_r <= {DATA_W{1'b0}};
        end else if (md_we_s) begin
            zhi_r <= md_hi_s;
            zlo_r <= md_lo_s;
        end else if (z_in && !alu_busy) begin
            zhi_r <= {DATA_W{1'b0}};
            zlo_r <= alu_res_s;
        end else begin
            zhi_r <= zhi_r;
            zlo_r <= zlo_r;
        end
    end

`ifdef DATAPATH_BUS_CHECK_EN
    logic [N_SPECIAL_SRC-1:0] spec_req_s;
    logic                     conflict_r;

    assign spec_req_s[SRC_HI]  = hi_out;
    assign spec_req_s[SRC_LO]  = lo_out;
    assign spec_req_s[SRC_ZHI] = zhi_out;
    assign spec_req_s[SRC_ZLO] = zlo_out;
    assign spec_req_s[SRC_PC]  = pc_out;
    assign spec_req_s[SRC_MDR] = mdr_out;

    // Sticky flag for any cycle with more than one bus driver requested
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            conflict_r <= 1'b0;
        end else if (multi_request(64'({r_out, spec_req_s}))) begin
            conflict_r <= 1'b1;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    assign bus_conflict = conflict_r;
`else
    assign bus_conflict = 1'b0;
`endif

    assign bus = bus_s;
    assign ir  = ir_r;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Bench for bus_datapath_seq: ALU vector table, directed MUL/DIV/reset/bus cases
// and random operations checked against a plain-arithmetic model.
module tb_bus_datapath_seq;
    import datapath_pkg::*;

    localparam int W = 32;
    localparam int N = 16;
`ifdef DATAPATH_BUS_CHECK_EN
    localparam logic EXP_CONF = 1'b1;
`else
    localparam logic EXP_CONF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic [N-1:0] r_in, r_out;
    logic         pc_in, pc_out, ir_in, y_in, hi_in, hi_out, lo_in, lo_out;
    logic         mdr_in, mdr_out, read, z_in, zhi_out, zlo_out, alu_start;
    logic [W-1:0] mdatain, bus, ir;
    logic [3:0]   alu_op;
    logic         alu_busy, alu_done, div_zero, bus_conflict;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] m_zhi, m_zlo;

    typedef struct {
        alu_op_e      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    bus_datapath_seq #(.DATA_W(W), .NREGS(N)) dut (
        .clk(clk), .clr(clr), .r_in(r_in), .r_out(r_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .y_in(y_in),
        .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .mdatain(mdatain),
        .z_in(z_in), .zhi_out(zhi_out), .zlo_out(zlo_out), .alu_op(alu_op),
        .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
        .div_zero(div_zero), .bus(bus), .ir(ir), .bus_conflict(bus_conflict)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        r_in = '0; r_out = '0; pc_in = 0; pc_out = 0; ir_in = 0; y_in = 0;
        hi_in = 0; hi_out = 0; lo_in = 0; lo_out = 0; mdr_in = 0; mdr_out = 0;
        read = 0; z_in = 0; zhi_out = 0; zlo_out = 0; alu_start = 0; alu_op = 4'd0;
        mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mdr(input logic [W-1:0] v);
        idle(); mdr_in = 1; read = 1; mdatain = v; tick(); idle();
    endtask

    task automatic set_y(input logic [W-1:0] v);
        set_mdr(v); mdr_out = 1; y_in = 1; tick(); idle();
    endtask

    task automatic set_reg(input int i, input logic [W-1:0] v);
        set_mdr(v); mdr_out = 1; r_in[i] = 1'b1; tick(); idle();
    endtask

    function automatic logic [W-1:0] alu_model(input alu_op_e op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int s;
        s = int'(b % 32);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOT: return ~b;
            ALU_NEG: return 0 - b;
            ALU_SHL: return a << s;
            ALU_SHR: return a >> s;
            ALU_ROL: return (a << s) | (a >> (32 - s));
            ALU_ROR: return (a >> s) | (a << (32 - s));
            default: return '0;
        endcase
    endfunction

    task automatic single_op(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp);
        set_y(a); set_mdr(b);
        mdr_out = 1; alu_op = op; z_in = 1;
        #1 check("alu_bus", bus, b);
        tick(); idle();
        check("alu_zlo", dut.zlo_r, exp);
        check("alu_zhi", dut.zhi_r, '0);
        zlo_out = 1;
        #1 check("zlo_drive", bus, exp);
        idle();
        m_zhi = '0; m_zlo = exp;
    endtask

    task automatic run_md(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        longint p, q, r;
        logic [W-1:0] eh, el;
        logic edz;
        int done_at;
        edz = 0;
        if (op == ALU_MUL) begin
            p = longint'($signed(a)) * longint'($signed(b));
            eh = p[63:32]; el = p[31:0];
        end else if (b == '0) begin
            eh = a; el = '1; edz = 1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            eh = r[31:0]; el = q[31:0];
        end
        set_y(a); set_mdr(b);
        mdr_out = 1; alu_op = op; alu_start = 1;
        tick(); idle();
        check("md_busy", {31'd0, alu_busy}, 1);
        if (!edz) check("dz_clear_on_start", {31'd0, div_zero}, 0);
        done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (poke && k == 5) begin
                mdr_out = 1; alu_op = ALU_ADD; z_in = 1; alu_start = 1;
            end
            tick(); idle();
            if (poke && k == 5) check("z_in_busy_ignored", dut.zlo_r, m_zlo);
            if (alu_done) begin
                done_at = k;
                break;
            end
        end
        check("md_latency", done_at, W + 1);
        check("md_zhi", dut.zhi_r, eh);
        check("md_zlo", dut.zlo_r, el);
        check("md_divzero", {31'd0, div_zero}, {31'd0, edz});
        check("md_idle", {31'd0, alu_busy}, 0);
        tick();
        check("done_pulse", {31'd0, alu_done}, 0);
        m_zhi = eh; m_zlo = el;
    endtask

    initial begin
        int ndone;
        alu_op_e op;
        logic [W-1:0] a, b;
        tbl[0]  = '{ALU_ADD, 32'h0000_0007, 32'h0000_0005, 32'h0000_000C};
        tbl[1]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[2]  = '{ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        tbl[3]  = '{ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        tbl[4]  = '{ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        tbl[5]  = '{ALU_NOT, 32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000};
        tbl[6]  = '{ALU_NEG, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[7]  = '{ALU_SHL, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
        tbl[8]  = '{ALU_SHR, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
        tbl[9]  = '{ALU_ROL, 32'h8000_0001, 32'h0000_0001, 32'h0000_0003};
        tbl[10] = '{ALU_ROR, 32'h8000_0001, 32'h0000_0001, 32'hC000_0000};
        tbl[11] = '{ALU_ROL, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        tbl[12] = '{ALU_ROR, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678};

        idle();
        clr = 0;
        #12;
        check("rst_busy", {31'd0, alu_busy}, 0);
        check("rst_done", {31'd0, alu_done}, 0);
        check("rst_divzero", {31'd0, div_zero}, 0);
        check("rst_conflict", {31'd0, bus_conflict}, 0);
        check("rst_bus_idle", bus, '0);
        #10 clr = 1;
        tick();
        zlo_out = 1;
        #1 check("rst_zlo", bus, '0);
        idle(); r_out[7] = 1'b1;
        #1 check("rst_r7", bus, '0);
        idle();
        m_zhi = '0; m_zlo = '0;

        set_mdr(32'hDEAD_BEEF); mdr_out = 1; ir_in = 1; tick(); idle();
        check("ir_load", ir, 32'hDEAD_BEEF);

        foreach (tbl[i]) single_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

        // R2 feeds the bus directly for Y=7 + R2=5
        set_reg(2, 32'd5); set_y(32'd7);
        r_out[2] = 1'b1; alu_op = ALU_ADD; z_in = 1;
        #1 check("r2_bus", bus, 32'd5);
        tick(); idle();
        check("r2_add_zlo", dut.zlo_r, 32'd12);
        check("r2_add_zhi", dut.zhi_r, 32'd0);
        m_zlo = 32'd12; m_zhi = '0;

        run_md(ALU_MUL, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_md(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_md(ALU_DIV, 32'd9, 32'd0, 1'b0);
        tick();
        check("dz_sticky", {31'd0, div_zero}, 1);
        run_md(ALU_MUL, 32'd5, 32'd6, 1'b0);
        run_md(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        for (int it = 0; it < 24; it++) begin
            op = alu_op_e'($urandom_range(0, 11));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (op == ALU_MUL || op == ALU_DIV) run_md(op, a, b, 1'b0);
            else single_op(op, a, b, alu_model(op, a, b));
        end

        // Reset in the middle of a multiply aborts it without a Z write
        set_y(32'd123); set_mdr(32'd456);
        mdr_out = 1; alu_op = ALU_MUL; alu_start = 1;
        tick(); idle();
        for (int k = 0; k < 9; k++) tick();
        #2 clr = 0;
        #1 check("abort_busy", {31'd0, alu_busy}, 0);
        check("abort_done", {31'd0, alu_done}, 0);
        zlo_out = 1;
        #1 check("abort_zlo", bus, '0);
        idle();
        tick();
        #2 clr = 1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (alu_done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        zhi_out = 1;
        #1 check("abort_zhi", bus, '0);
        idle();
        check("no_conflict_yet", {31'd0, bus_conflict}, 0);

        set_reg(1, 32'hA5A5_A5A5);
        set_mdr(32'h0000_1111); mdr_out = 1; pc_in = 1; tick(); idle();
        pc_out = 1;
        #1 check("pc_drive", bus, 32'h0000_1111);
        r_out[1] = 1'b1;
        #1 check("prio_r1_over_pc", bus, 32'hA5A5_A5A5);
        tick(); idle();
        check("conflict_set", {31'd0, bus_conflict}, {31'd0, EXP_CONF});
        tick(); tick();
        check("conflict_hold", {31'd0, bus_conflict}, {31'd0, EXP_CONF});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
